vdma_wr_sched: RTL and testbench

Write-side burst scheduler for the VDMA input path. It sits between the input port's aligned stream (frame, line and end markers plus data-valid) and the AXI write master. It tracks line and frame position, waits until the write FIFO holds enough words, then issues address/length burst requests. Frame buffers rotate so the buffer currently being read is never overwritten.

---
 rtl/vdma_pkg.sv | 19 +
 rtl/fb_index_rotator.sv | 54 +++++
 rtl/vdma_wr_sched.sv | 189 ++++++++++++++++++
 tb/tb_vdma_wr_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vdma_pkg.sv
// Shared types for the VDMA write path: scheduler states, burst length width
// and frame-buffer index type.
`timescale 1ns/1ps
package vdma_pkg;

  localparam int LEN_W = 9;

  typedef logic [1:0] fb_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_WAIT_DATA,
    S_REQ,
    S_BUSY,
    S_FRAME_END
  } wr_state_t;

endpackage

// File: rtl/fb_index_rotator.sv
// Frame-buffer rotation for the write side: picks the next buffer while
// steering around the one the reader owns, and keeps the buffer base offset.
`timescale 1ns/1ps
module fb_index_rotator
  import vdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FB_NUM     = 3
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  advance,
  input  fb_idx_t               rd_fb_index,
  input  logic [ADDR_WIDTH-1:0] fb_base,
  input  logic [ADDR_WIDTH-1:0] frame_stride,
  output fb_idx_t               wr_fb_index,
  output logic [ADDR_WIDTH-1:0] frame_base
);

  logic [ADDR_WIDTH-1:0] off_r;
  logic [ADDR_WIDTH-1:0] off1;
  logic [ADDR_WIDTH-1:0] off2;
  fb_idx_t               idx1;
  fb_idx_t               idx2;

  function automatic fb_idx_t idx_inc(input fb_idx_t i);
    return (i == fb_idx_t'(FB_NUM - 1)) ? '0 : fb_idx_t'(i + 2'd1);
  endfunction

  // Offset restarts at zero on wrap, otherwise grows by one stride per step.
  always_comb begin
    idx1 = idx_inc(wr_fb_index);
    off1 = (idx1 == '0) ? '0 : off_r + frame_stride;
    idx2 = idx1;
    off2 = off1;
    if ((FB_NUM == 3) && (idx1 == rd_fb_index)) begin
      idx2 = idx_inc(idx1);
      off2 = (idx2 == '0) ? '0 : off1 + frame_stride;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_fb_index <= '0;
      off_r       <= '0;
    end else if (advance) begin
      wr_fb_index <= idx2;
      off_r       <= off2;
    end
  end

  assign frame_base = fb_base + off_r;

endmodule

// File: rtl/vdma_wr_sched.sv
// Write-side burst scheduler: follows line/frame position of the input stream
// and issues address/length burst requests once the write FIFO holds enough.
`timescale 1ns/1ps
module vdma_wr_sched
  import vdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 64,
  parameter int BPB        = 4,
  parameter int FB_NUM     = 3
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           vactive,
  input  logic [15:0]           hactive,
  input  logic [ADDR_WIDTH-1:0] fb_base,
  input  logic [ADDR_WIDTH-1:0] frame_stride,
  input  logic [ADDR_WIDTH-1:0] line_stride,
  input  logic                  falign,
  input  logic                  lalign,
  input  logic                  ealign,
  input  logic                  data_vld,
  input  logic [15:0]           fifo_count,
  input  fb_idx_t               rd_fb_index,
  output logic                  burst_req,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [LEN_W-1:0]      burst_len,
  input  logic                  burst_ack,
  input  logic                  burst_done,
  output fb_idx_t               wr_fb_index,
  output logic                  frame_done,
  output logic                  sync_err
);

  localparam int          BPB_SH    = $clog2(BPB);
  localparam logic [15:0] MAX_LEN16 = 16'(BURST_LEN);

  wr_state_t             state, state_nxt;
  logic [15:0]           hact_r, vact_r;
  logic [15:0]           line_cnt, beat_rem, rem_nxt;
  logic [ADDR_WIDTH-1:0] line_addr, beat_off, frame_base;
  logic [LEN_W-1:0]      len_sel;
  logic                  restart_pend;
  logic                  fifo_ok, cfg_in_ok, cfg_r_ok;
  logic                  premature, capture, upd, line_end, frame_last;
  logic [15:0]           pix_cnt, line_seen, pix_this, line_base;
  logic                  mark_err;
  logic                  unused_mark;

  function automatic logic [LEN_W-1:0] clip_len(input logic [15:0] rem);
    return (rem >= MAX_LEN16) ? LEN_W'(BURST_LEN) : rem[LEN_W-1:0];
  endfunction

  assign len_sel    = clip_len(beat_rem);
  assign fifo_ok    = fifo_count >= 16'(len_sel);
  assign cfg_in_ok  = (hactive != '0) && (vactive != '0);
  assign cfg_r_ok   = (hact_r != '0) && (vact_r != '0);
  assign premature  = falign && (state inside {S_WAIT_DATA, S_REQ, S_BUSY});
  assign capture    = falign && (premature || (state == S_WAIT_FRAME) ||
                                 ((state == S_FRAME_END) && enable));
  assign rem_nxt    = beat_rem - 16'(burst_len);
  assign line_end   = (rem_nxt == '0);
  assign frame_last = line_end && ((line_cnt + 16'd1) == vact_r);
  // A restart pending from a premature falign discards the finishing burst's progress.
  assign upd        = (state == S_BUSY) && burst_done && !falign && !restart_pend;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (enable) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: if (falign && cfg_in_ok) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (falign)       state_nxt = cfg_in_ok ? S_WAIT_DATA : S_WAIT_FRAME;
        else if (fifo_ok) state_nxt = S_REQ;
      end
      S_REQ:        if (burst_ack) state_nxt = S_BUSY;
      S_BUSY: begin
        if (burst_done) begin
          if (falign)            state_nxt = cfg_in_ok ? S_WAIT_DATA : S_WAIT_FRAME;
          else if (restart_pend) state_nxt = cfg_r_ok ? S_WAIT_DATA : S_WAIT_FRAME;
          else if (frame_last)   state_nxt = S_FRAME_END;
          else                   state_nxt = S_WAIT_DATA;
        end
      end
      S_FRAME_END: begin
        if (!enable)                  state_nxt = S_IDLE;
        else if (falign && cfg_in_ok) state_nxt = S_WAIT_DATA;
        else                          state_nxt = S_WAIT_FRAME;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      burst_req    <= 1'b0;
      burst_addr   <= '0;
      burst_len    <= '0;
      frame_done   <= 1'b0;
      sync_err     <= 1'b0;
      restart_pend <= 1'b0;
      line_cnt     <= '0;
      beat_rem     <= '0;
    end else begin
      frame_done <= (state == S_BUSY) && (state_nxt == S_FRAME_END);
      sync_err   <= premature;

      if ((state == S_WAIT_DATA) && !falign && fifo_ok) begin
        burst_req  <= 1'b1;
        burst_addr <= frame_base + line_addr + beat_off;
        burst_len  <= len_sel;
      end else if ((state == S_REQ) && burst_ack) begin
        burst_req  <= 1'b0;
      end

      if (capture)
        restart_pend <= (state == S_REQ) || ((state == S_BUSY) && !burst_done);
      else if ((state == S_BUSY) && burst_done)
        restart_pend <= 1'b0;

      if (capture) begin
        line_cnt <= '0;
        beat_rem <= hactive;
      end else if (upd) begin
        if (line_end) begin
          line_cnt <= line_cnt + 16'd1;
          beat_rem <= hact_r;
        end else begin
          beat_rem <= rem_nxt;
        end
      end
    end
  end

  // Geometry and address accumulators only matter after a capture.
  always_ff @(posedge clock) begin
    if (capture) begin
      hact_r    <= hactive;
      vact_r    <= vactive;
      line_addr <= '0;
      beat_off  <= '0;
    end else if (upd) begin
      if (line_end) begin
        line_addr <= line_addr + line_stride;
        beat_off  <= '0;
      end else begin
        beat_off  <= beat_off + (ADDR_WIDTH'(burst_len) << BPB_SH);
      end
    end
  end

  // Marker cross-check: flag kept for debug probing, never steers the schedule.
  assign pix_this  = (falign ? 16'd0 : pix_cnt) + 16'd1;
  assign line_base = falign ? 16'd0 : line_seen;

  always_ff @(posedge clock) begin
    if (data_vld) begin
      mark_err  <= (lalign && (pix_this != hact_r)) ||
                   (ealign && ((line_base + 16'd1) != vact_r));
      pix_cnt   <= lalign ? 16'd0 : pix_this;
      line_seen <= ealign ? 16'd0 : (lalign ? line_base + 16'd1 : line_base);
    end else begin
      mark_err  <= 1'b0;
    end
  end

  assign unused_mark = mark_err;

  fb_index_rotator #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FB_NUM     (FB_NUM)
  ) u_rot (
    .clock        (clock),
    .rst_n        (rst_n),
    .advance      (state == S_FRAME_END),
    .rd_fb_index  (rd_fb_index),
    .fb_base      (fb_base),
    .frame_stride (frame_stride),
    .wr_fb_index  (wr_fb_index),
    .frame_base   (frame_base)
  );

endmodule

// File: tb/tb_vdma_wr_sched.sv
// Directed bench for vdma_wr_sched: burst sequencing, FIFO threshold, buffer
// rotation, premature frame restart and asynchronous reset.
`timescale 1ns/1ps
module tb_vdma_wr_sched;
  import vdma_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] vactive = '0, hactive = '0;
  logic [31:0] fb_base = '0, frame_stride = '0, line_stride = '0;
  logic        falign = 1'b0, lalign = 1'b0, ealign = 1'b0, data_vld = 1'b0;
  logic [15:0] fifo_count = '0;
  fb_idx_t     rd_fb_index = '0;
  logic        burst_req;
  logic [31:0] burst_addr;
  logic [8:0]  burst_len;
  logic        burst_ack = 1'b0, burst_done = 1'b0;
  fb_idx_t     wr_fb_index;
  logic        frame_done, sync_err;

  int n_vec = 0;
  int n_err = 0;

  vdma_wr_sched #(.ADDR_WIDTH(32), .BURST_LEN(64), .BPB(4), .FB_NUM(3)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .vactive(vactive), .hactive(hactive),
    .fb_base(fb_base), .frame_stride(frame_stride), .line_stride(line_stride),
    .falign(falign), .lalign(lalign), .ealign(ealign), .data_vld(data_vld),
    .fifo_count(fifo_count), .rd_fb_index(rd_fb_index), .burst_req(burst_req),
    .burst_addr(burst_addr), .burst_len(burst_len), .burst_ack(burst_ack),
    .burst_done(burst_done), .wr_fb_index(wr_fb_index), .frame_done(frame_done),
    .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_falign();
    falign   = 1'b1;
    data_vld = 1'b1;
    step();
    falign   = 1'b0;
    data_vld = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a, input logic [8:0] l);
    int n = 0;
    while (!burst_req && n < 40) begin
      step();
      n++;
    end
    check_val({tag, "_req"}, 64'(burst_req), 64'd1);
    check_val({tag, "_addr"}, 64'(burst_addr), 64'(a));
    check_val({tag, "_len"}, 64'(burst_len), 64'(l));
  endtask

  task automatic ack_burst(input string tag);
    burst_ack = 1'b1;
    step();
    burst_ack = 1'b0;
    check_val({tag, "_req_drop"}, 64'(burst_req), 64'd0);
  endtask

  task automatic done_burst(input string tag, input logic fd);
    step();
    step();
    burst_done = 1'b1;
    step();
    burst_done = 1'b0;
    check_val({tag, "_fdone"}, 64'(frame_done), 64'(fd));
  endtask

  task automatic burst(input string tag, input logic [31:0] a, input logic [8:0] l, input logic fd);
    wait_req(tag, a, l);
    ack_burst(tag);
    done_burst(tag, fd);
  endtask

  initial begin
    logic seen;

    repeat (3) step();
    check_val("rst_req", 64'(burst_req), 64'd0);
    check_val("rst_addr", 64'(burst_addr), 64'd0);
    check_val("rst_len", 64'(burst_len), 64'd0);
    check_val("rst_wridx", 64'(wr_fb_index), 64'd0);
    check_val("rst_fdone", 64'(frame_done), 64'd0);
    check_val("rst_serr", 64'(sync_err), 64'd0);

    // Frame 1, buffer 0: two lines of 128 pixels -> four full bursts.
    rst_n        = 1'b1;
    enable       = 1'b1;
    hactive      = 16'd128;
    vactive      = 16'd2;
    fb_base      = 32'h1000;
    frame_stride = 32'h10000;
    line_stride  = 32'h400;
    fifo_count   = 16'd200;
    rd_fb_index  = 2'd1;
    step();
    pulse_falign();
    burst("f1b0", 32'h1000, 9'd64, 1'b0);
    burst("f1b1", 32'h1100, 9'd64, 1'b0);
    burst("f1b2", 32'h1400, 9'd64, 1'b0);
    burst("f1b3", 32'h1500, 9'd64, 1'b1);
    step();
    check_val("f1_fdone_pulse", 64'(frame_done), 64'd0);
    check_val("f1_next_idx", 64'(wr_fb_index), 64'd2);

    // Frame 2, buffer 2 (buffer 1 is being read): 100-pixel lines split 64+36.
    hactive = 16'd100;
    pulse_falign();
    burst("f2b0", 32'h21000, 9'd64, 1'b0);
    burst("f2b1", 32'h21100, 9'd36, 1'b0);
    burst("f2b2", 32'h21400, 9'd64, 1'b0);
    burst("f2b3", 32'h21500, 9'd36, 1'b1);
    step();
    check_val("f2_next_idx", 64'(wr_fb_index), 64'd0);

    // Frame 3, buffer 0: FIFO threshold holds the request back.
    hactive    = 16'd64;
    vactive    = 16'd1;
    fifo_count = 16'd30;
    pulse_falign();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= burst_req;
    end
    check_val("f3_hold_low", 64'(seen), 64'd0);
    fifo_count = 16'd64;
    step();
    check_val("f3_req_next", 64'(burst_req), 64'd1);
    burst("f3b0", 32'h1000, 9'd64, 1'b1);
    step();
    check_val("f3_next_idx", 64'(wr_fb_index), 64'd2);

    // Frame 4, buffer 2: premature falign while the line-1 burst is in flight.
    hactive    = 16'd128;
    vactive    = 16'd2;
    fifo_count = 16'd200;
    pulse_falign();
    burst("f4b0", 32'h21000, 9'd64, 1'b0);
    burst("f4b1", 32'h21100, 9'd64, 1'b0);
    wait_req("f4b2", 32'h21400, 9'd64);
    ack_burst("f4b2");
    pulse_falign();
    check_val("f4_serr", 64'(sync_err), 64'd1);
    step();
    check_val("f4_serr_pulse", 64'(sync_err), 64'd0);
    burst_done = 1'b1;
    step();
    burst_done = 1'b0;
    check_val("f4_no_fdone", 64'(frame_done), 64'd0);
    wait_req("f4_restart", 32'h21000, 9'd64);
    check_val("f4_same_idx", 64'(wr_fb_index), 64'd2);

    // Asynchronous reset with a request outstanding.
    rst_n = 1'b0;
    #1;
    check_val("arst_req", 64'(burst_req), 64'd0);
    check_val("arst_addr", 64'(burst_addr), 64'd0);
    check_val("arst_len", 64'(burst_len), 64'd0);
    check_val("arst_wridx", 64'(wr_fb_index), 64'd0);
    step();
    step();
    enable = 1'b0;
    rst_n  = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= burst_req;
    end
    pulse_falign();
    for (int i = 0; i < 8; i++) begin
      step();
      seen |= burst_req;
    end
    check_val("post_rst_disabled", 64'(seen), 64'd0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      seen |= burst_req;
    end
    check_val("post_rst_no_falign", 64'(seen), 64'd0);
    pulse_falign();
    wait_req("post_rst", 32'h1000, 9'd64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
